screen_dump_sequencer: RTL and testbench
========================================

Name: screen_dump_sequencer

Overview:
- Fabric-side partner of the Nios screen-reader subsystem; sits between the frame buffer and the Nios PIO ports (events/response/address/data).
- On a dump request: freezes the frame buffer and raises a start event to the Nios.
- Serves each pixel read the Nios requests by address, using a four-phase level handshake.
- Reports completion or abort back to the display logic.

Parameters:
- ADDR_W, 20, frame-buffer address width; matches the Nios output address port.
- DATA_W, 16, pixel width; matches the Nios input data port.
- FB_DEPTH, 786432, number of valid frame-buffer words.
- TIMEOUT_CYCLES, 50000000, idle cycles allowed waiting on the Nios before abort (1 s at 50 MHz).

Ports:
- clk_clk  in  1  system clock; all logic on its rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- dump_start  in  1  one-cycle request to begin a screen dump.
- dump_abort  in  1  one-cycle user abort.
- events  out  3  to Nios events PIO: [0] start_req, [1] data_valid, [2] abort.
- response  in  3  from Nios response PIO: [0] start_ack, [1] addr_req, [2] done.
- req_address  in  ADDR_W  from Nios address PIO; sampled only when addr_req rises.
- pixel_data  out  DATA_W  to Nios input-data PIO.
- fb_rd_req  out  1  one-cycle frame-buffer read strobe.
- fb_addr  out  ADDR_W  frame-buffer read address.
- fb_rd_data  in  DATA_W  frame-buffer read data.
- fb_rd_valid  in  1  fb_rd_data valid this cycle; arrives any number of cycles (≥1) after fb_rd_req.
- fb_freeze  out  1  inhibits acquisition writes while high.
- dump_busy  out  1  high in every state except IDLE.
- dump_done  out  1  one-cycle pulse on successful completion.
- dump_error  out  1  sticky abort/timeout flag; cleared at next accepted dump_start.
- pixel_count  out  ADDR_W  pixels served in the current dump.

Behaviour:
- Reset values: all outputs 0; state IDLE; watchdog 0.
- States: IDLE, START, WAIT_ADDR, FETCH, PRESENT, FINISH, ABORT.
- Watchdog: 32-bit counter; clears on every state change; increments in START, WAIT_ADDR, PRESENT, FINISH; saturates. Reaching TIMEOUT_CYCLES moves to ABORT.
- IDLE, on dump_start:
  - Next cycle: events[0]=1, fb_freeze=1, pixel_count=0, dump_error=0; go to START.
  - dump_start in any other state is ignored.
- START: response[0]=1 -> WAIT_ADDR.
- WAIT_ADDR:
  - response[2]=1 -> FINISH. Done has priority when [1] and [2] are both high.
  - Else response[1]=1 -> latch req_address into fb_addr, pulse fb_rd_req for exactly one cycle, go to FETCH.
- FETCH:
  - Not watchdog-timed.
  - On fb_rd_valid: register fb_rd_data into pixel_data, events[1]=1, pixel_count+1 (wraps modulo 2^ADDR_W), go to PRESENT.
  - fb_rd_valid outside FETCH is ignored.
- PRESENT: hold pixel_data stable; response[1]=0 -> events[1]=0, go to WAIT_ADDR.
- Minimum pixel round trip: 4 cycles plus frame-buffer latency.
- FINISH:
  - events[0]=0.
  - When response[0]=0: one-cycle dump_done, fb_freeze=0, go to IDLE.
- ABORT:
  - events=3'b100, dump_error=1.
  - When response==0: events=0, fb_freeze=0, go to IDLE. No dump_done.
- dump_abort in any non-IDLE state -> ABORT next cycle. Exception: in FETCH, the abort is deferred until fb_rd_valid, and that read data is discarded.
- pixel_data retains its last value outside PRESENT.
- Asynchronous reset mid-dump: immediate return to IDLE with all outputs 0, including fb_freeze release.

Optional Feature:
- Macro SCREEN_DUMP_ADDR_CHECK_EN.
- Defined: in WAIT_ADDR, a req_address ≥ FB_DEPTH issues no fb_rd_req. The block goes directly to PRESENT with pixel_data=0 and sets dump_error; the dump continues normally and pixel_count still increments.
- Undefined: every address is forwarded unchanged to fb_addr.

Test Plan:
- Normal dump:
  - Stimulus: dump_start; Nios acks; requests addresses 0, 1, 2 (fb data 0xA001, 0xA002, 0xA003, 2-cycle latency); asserts done.
  - Required: pixel_data matches each word while events[1]=1; pixel_count=3; one dump_done pulse; fb_freeze low after response[0] drops.
- Start timeout:
  - Stimulus: TIMEOUT_CYCLES=100; dump_start; Nios never acks.
  - Required: ABORT at cycle 100 (events=3'b100, dump_error=1); IDLE once response==0.
- Abort during FETCH:
  - Stimulus: dump_abort while fb latency=5.
  - Required: fb_rd_valid consumed; events[1] never rises; ABORT entered; pixel_count unchanged.
- Simultaneous done and addr_req:
  - Stimulus: response=3'b111 in WAIT_ADDR.
  - Required: FINISH; no fb_rd_req.
- Reset mid-PRESENT:
  - Stimulus: reset_reset_n low.
  - Required: all outputs 0 asynchronously; next dump_start starts cleanly with pixel_count=0.
- With SCREEN_DUMP_ADDR_CHECK_EN:
  - Stimulus: req_address=0xC0000.
  - Required: no fb_rd_req; pixel_data=0; dump_error=1; handshake completes.

Source files
------------

// File: rtl/screen_dump_sequencer.sv
// Fabric-side screen-dump sequencer: freezes the frame buffer and serves Nios pixel reads over a level handshake.
// Optional SCREEN_DUMP_ADDR_CHECK_EN: out-of-range read addresses return 0 and flag dump_error.
module screen_dump_sequencer #(
    parameter int unsigned ADDR_W         = 20,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned FB_DEPTH       = 786432,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              dump_start,
    input  logic              dump_abort,
    output logic [2:0]        events,
    input  logic [2:0]        response,
    input  logic [ADDR_W-1:0] req_address,
    output logic [DATA_W-1:0] pixel_data,
    output logic              fb_rd_req,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [DATA_W-1:0] fb_rd_data,
    input  logic              fb_rd_valid,
    output logic              fb_freeze,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              dump_error,
    output logic [ADDR_W-1:0] pixel_count
);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_ADDR, FETCH, PRESENT, FINISH, ABORT
    } state_t;

    localparam logic [31:0] WD_LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] watchdog;
    logic        abort_pending;
    logic        timed;
    logic        wd_expired;
    logic        to_abort;
    logic        addr_oob;

    if (ADDR_W < 32 && FB_DEPTH > (32'd1 << ADDR_W)) begin : g_depth_check
        $error("FB_DEPTH exceeds the addressable range of ADDR_W");
    end

`ifdef SCREEN_DUMP_ADDR_CHECK_EN
    assign addr_oob = {1'b0, req_address} >= (ADDR_W + 1)'(FB_DEPTH);
`else
    assign addr_oob = 1'b0;
`endif

    assign timed      = (state == START) || (state == WAIT_ADDR) ||
                        (state == PRESENT) || (state == FINISH);
    assign wd_expired = timed && (watchdog >= WD_LIMIT);

    // An abort seen in FETCH is held until the outstanding read returns, so the
    // frame buffer never delivers data into a state that no longer expects it.
    always_comb begin
        to_abort = 1'b0;
        if (timed)
            to_abort = dump_abort || wd_expired;
        else if (state == FETCH)
            to_abort = fb_rd_valid && (abort_pending || dump_abort);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= IDLE;
            watchdog      <= '0;
            abort_pending <= 1'b0;
            events        <= '0;
            pixel_data    <= '0;
            fb_rd_req     <= 1'b0;
            fb_addr       <= '0;
            fb_freeze     <= 1'b0;
            dump_busy     <= 1'b0;
            dump_done     <= 1'b0;
            dump_error    <= 1'b0;
            pixel_count   <= '0;
        end else begin
            fb_rd_req <= 1'b0;
            dump_done <= 1'b0;
            if (timed && watchdog != '1)
                watchdog <= watchdog + 32'd1;

            if (to_abort) begin
                state         <= ABORT;
                watchdog      <= '0;
                abort_pending <= 1'b0;
                events        <= 3'b100;
                dump_error    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (dump_start) begin
                            state         <= START;
                            watchdog      <= '0;
                            abort_pending <= 1'b0;
                            events        <= 3'b001;
                            fb_freeze     <= 1'b1;
                            dump_busy     <= 1'b1;
                            dump_error    <= 1'b0;
                            pixel_count   <= '0;
                        end
                    end
                    START: begin
                        if (response[0]) begin
                            state    <= WAIT_ADDR;
                            watchdog <= '0;
                        end
                    end
                    WAIT_ADDR: begin
                        if (response[2]) begin
                            state     <= FINISH;
                            watchdog  <= '0;
                            events[0] <= 1'b0;
                        end else if (response[1] && addr_oob) begin
                            state       <= PRESENT;
                            watchdog    <= '0;
                            pixel_data  <= '0;
                            events[1]   <= 1'b1;
                            pixel_count <= pixel_count + 1'b1;
                            dump_error  <= 1'b1;
                        end else if (response[1]) begin
                            state     <= FETCH;
                            watchdog  <= '0;
                            fb_addr   <= req_address;
                            fb_rd_req <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (dump_abort)
                            abort_pending <= 1'b1;
                        if (fb_rd_valid) begin
                            state       <= PRESENT;
                            watchdog    <= '0;
                            pixel_data  <= fb_rd_data;
                            events[1]   <= 1'b1;
                            pixel_count <= pixel_count + 1'b1;
                        end
                    end
                    PRESENT: begin
                        if (!response[1]) begin
                            state     <= WAIT_ADDR;
                            watchdog  <= '0;
                            events[1] <= 1'b0;
                        end
                    end
                    FINISH: begin
                        if (!response[0]) begin
                            state     <= IDLE;
                            watchdog  <= '0;
                            dump_done <= 1'b1;
                            fb_freeze <= 1'b0;
                            dump_busy <= 1'b0;
                        end
                    end
                    ABORT: begin
                        if (response == 3'b000) begin
                            state     <= IDLE;
                            watchdog  <= '0;
                            events    <= '0;
                            fb_freeze <= 1'b0;
                            dump_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        watchdog <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_screen_dump_sequencer.sv
// Scoreboard bench for screen_dump_sequencer: Nios handshake model plus a variable-latency frame-buffer model.
// Define SCREEN_DUMP_ADDR_CHECK_EN for both files to exercise the address-range check.
module tb_screen_dump_sequencer;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dump_start;
    logic              dump_abort;
    logic [2:0]        events;
    logic [2:0]        response;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] pixel_data;
    logic              fb_rd_req;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_rd_data;
    logic              fb_rd_valid;
    logic              fb_freeze;
    logic              dump_busy;
    logic              dump_done;
    logic              dump_error;
    logic [ADDR_W-1:0] pixel_count;

    always #5 clk = ~clk;

    screen_dump_sequencer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .FB_DEPTH(786432),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .dump_start(dump_start),
        .dump_abort(dump_abort),
        .events(events),
        .response(response),
        .req_address(req_address),
        .pixel_data(pixel_data),
        .fb_rd_req(fb_rd_req),
        .fb_addr(fb_addr),
        .fb_rd_data(fb_rd_data),
        .fb_rd_valid(fb_rd_valid),
        .fb_freeze(fb_freeze),
        .dump_busy(dump_busy),
        .dump_done(dump_done),
        .dump_error(dump_error),
        .pixel_count(pixel_count)
    );

    int                tests = 0;
    int                fails = 0;
    int                cnt_req = 0;
    int                valid_cnt = 0;
    int                done_cnt = 0;
    int                lat = 2;
    int                exp_cnt = 0;
    bit                dv_seen = 1'b0;
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] fb_a;

    function automatic logic [DATA_W-1:0] mem(input logic [ADDR_W-1:0] a);
        return 16'hA001 + a[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-buffer model: answers each read strobe after lat cycles.
    initial begin
        fb_rd_valid = 1'b0;
        fb_rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (fb_rd_req === 1'b1) begin
                fb_a = fb_addr;
                cnt_req++;
                repeat (lat) @(posedge clk);
                #1;
                fb_rd_data  = mem(fb_a);
                fb_rd_valid = 1'b1;
                @(posedge clk);
                #1;
                fb_rd_valid = 1'b0;
                valid_cnt++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (dump_done === 1'b1) done_cnt++;
        if (events[1] === 1'b1) dv_seen = 1'b1;
    end

    task automatic wait_ev(input string tag, input int b, input logic v);
        int n = 0;
        while (events[b] !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(events[b]), 32'(v));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dump_busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dump_busy), 32'd0);
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        wait_ev("start_req", 0, 1'b1);
        exp_cnt = 0;
    endtask

    task automatic ack();
        response[0] = 1'b1;
        @(negedge clk);
    endtask

    task automatic serve_pixel(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        req_address = a;
        response[1] = 1'b1;
        exp_q.push_back(exp);
        wait_ev("data_valid_rise", 1, 1'b1);
        if (exp_q.size() > 0) check("pixel_data", 32'(pixel_data), 32'(exp_q.pop_front()));
        exp_cnt++;
        check("pixel_count", 32'(pixel_count), 32'(exp_cnt));
        @(negedge clk);
        check("pixel_hold", 32'(pixel_data), 32'(exp));
        response[1] = 1'b0;
        wait_ev("data_valid_fall", 1, 1'b0);
    endtask

    task automatic finish_dump();
        response[2] = 1'b1;
        wait_ev("finish_start_req_low", 0, 1'b0);
        check("freeze_held_in_finish", 32'(fb_freeze), 32'd1);
        response = 3'b000;
        wait_idle("finish_idle");
        check("freeze_released", 32'(fb_freeze), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not end, failed %0d", fails);
        $fatal(1, "global timeout");
    end

    initial begin
        int done_before;
        int req_before;
        int valid_before;
        int cyc;

        rst_n = 1'b0;
        dump_start = 1'b0;
        dump_abort = 1'b0;
        response = 3'b000;
        req_address = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {events, fb_freeze, dump_busy, dump_done, dump_error, fb_rd_req}, 32'd0);
        check("reset_pixel_data", 32'(pixel_data), 32'd0);
        check("reset_pixel_count", 32'(pixel_count), 32'd0);
        check("reset_fb_addr", 32'(fb_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal dump of three pixels
        lat = 2;
        start_dump();
        check("start_freeze", 32'(fb_freeze), 32'd1);
        check("start_busy", 32'(dump_busy), 32'd1);
        ack();
        for (int i = 0; i < 3; i++)
            serve_pixel(ADDR_W'(i), 16'(16'hA001 + i));
        check("normal_count", 32'(pixel_count), 32'd3);
        check("normal_reads", 32'(cnt_req), 32'd3);
        finish_dump();
        check("normal_done_pulse", 32'(done_cnt), 32'd1);
        check("normal_no_error", 32'(dump_error), 32'd0);

        // Start timeout: no acknowledge ever arrives
        response = 3'b100;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        cyc = 0;
        while (events !== 3'b100 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", 32'(cyc), 32'd100);
        check("timeout_events", 32'(events), 32'b100);
        check("timeout_error", 32'(dump_error), 32'd1);
        repeat (3) @(negedge clk);
        check("abort_waits_response", 32'(dump_busy), 32'd1);
        response = 3'b000;
        wait_idle("timeout_idle");
        check("timeout_events_clear", 32'(events), 32'd0);
        check("timeout_freeze", 32'(fb_freeze), 32'd0);
        check("timeout_no_done", 32'(done_cnt), 32'd1);
        check("error_sticky", 32'(dump_error), 32'd1);

        // Abort while a slow read is outstanding
        start_dump();
        check("error_cleared_on_start", 32'(dump_error), 32'd0);
        ack();
        serve_pixel(20'd5, mem(20'd5));
        lat = 5;
        req_before = cnt_req;
        valid_before = valid_cnt;
        req_address = 20'd7;
        response[1] = 1'b1;
        cyc = 0;
        while (cnt_req == req_before && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_fetch_req", 32'(cnt_req), 32'(req_before + 1));
        dv_seen = 1'b0;
        dump_abort = 1'b1;
        @(negedge clk);
        dump_abort = 1'b0;
        cyc = 0;
        while (events !== 3'b100 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_fetch_events", 32'(events), 32'b100);
        check("abort_fetch_consumed", 32'(valid_cnt), 32'(valid_before + 1));
        check("abort_fetch_no_dv", 32'(dv_seen), 32'd0);
        check("abort_fetch_count", 32'(pixel_count), 32'd1);
        check("abort_fetch_pixel_kept", 32'(pixel_data), 32'(mem(20'd5)));
        response = 3'b000;
        wait_idle("abort_fetch_idle");
        lat = 2;

        // Done and addr_req together: done wins
        start_dump();
        ack();
        repeat (2) @(negedge clk);
        req_before = cnt_req;
        done_before = done_cnt;
        req_address = 20'd3;
        response = 3'b111;
        wait_ev("both_finish", 0, 1'b0);
        repeat (4) @(negedge clk);
        check("both_no_read", 32'(cnt_req), 32'(req_before));
        check("both_no_dv", 32'(events[1]), 32'd0);
        response = 3'b000;
        wait_idle("both_idle");
        check("both_done_pulse", 32'(done_cnt), 32'(done_before + 1));

        // Asynchronous reset while presenting a pixel
        start_dump();
        ack();
        req_address = 20'd2;
        response[1] = 1'b1;
        wait_ev("rst_present", 1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {events, fb_freeze, dump_busy, dump_done, dump_error, fb_rd_req}, 32'd0);
        check("async_rst_pixel", 32'(pixel_data), 32'd0);
        check("async_rst_count", 32'(pixel_count), 32'd0);
        @(negedge clk);
        response = 3'b000;
        rst_n = 1'b1;
        @(negedge clk);
        start_dump();
        check("post_rst_count", 32'(pixel_count), 32'd0);
        ack();
        serve_pixel(20'd9, mem(20'd9));
        done_before = done_cnt;
        finish_dump();
        check("post_rst_done", 32'(done_cnt), 32'(done_before + 1));

        // Address at FB_DEPTH
        start_dump();
        ack();
        req_before = cnt_req;
`ifdef SCREEN_DUMP_ADDR_CHECK_EN
        serve_pixel(20'hC0000, 16'h0000);
        check("oob_no_read", 32'(cnt_req), 32'(req_before));
        check("oob_error", 32'(dump_error), 32'd1);
        serve_pixel(20'd4, mem(20'd4));
        check("oob_count", 32'(pixel_count), 32'd2);
`else
        serve_pixel(20'hC0000, mem(20'hC0000));
        check("far_addr_read", 32'(cnt_req), 32'(req_before + 1));
        check("far_addr_forward", 32'(fb_addr), 32'hC0000);
        check("far_addr_no_error", 32'(dump_error), 32'd0);
`endif
        done_before = done_cnt;
        finish_dump();
        check("last_done", 32'(done_cnt), 32'(done_before + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
